// File: rtl/mem_disp_ctrl_if.sv
// Bundles the scan, host, clear-control and display-memory port signals of mem_disp_ctrl.
interface mem_disp_ctrl_if;
  localparam int unsigned AW = 10;

  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic          scan_vld;
  logic          scan_pix;

  logic          host_req;
  logic          host_wr;
  logic [AW-1:0] host_addr;
  logic          host_din;
  logic          host_gnt;
  logic          host_rvld;
  logic          host_dout;

  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;

  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic          mem_d;
  logic          mem_q;

  // Requesters plus the memory itself
  modport master (
    output scan_req, scan_addr, host_req, host_wr, host_addr, host_din, clr_start, mem_q,
    input  scan_vld, scan_pix, host_gnt, host_rvld, host_dout, clr_busy, clr_done,
    input  mem_wr, mem_addr, mem_d
  );

  // The access controller
  modport slave (
    input  scan_req, scan_addr, host_req, host_wr, host_addr, host_din, clr_start, mem_q,
    output scan_vld, scan_pix, host_gnt, host_rvld, host_dout, clr_busy, clr_done,
    output mem_wr, mem_addr, mem_d
  );
endinterface

// File: rtl/mem_disp_ctrl.sv
// Fixed-priority arbiter for the single display-memory port: scan reader first,
// then the full-memory clear engine, then the host.
module mem_disp_ctrl #(
  parameter logic CLR_VAL = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_disp_ctrl_if.slave bus
);
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1024;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic { IDLE = 1'b0, CLEAR = 1'b1 } state_t;
  typedef enum logic [1:0] { TAG_NONE = 2'd0, TAG_SCAN = 2'd1, TAG_HOST = 2'd2 } tag_t;

  state_t        state_q, state_nxt;
  logic [AW-1:0] clr_cnt_q, clr_cnt_nxt;
  tag_t          tag_q, tag_nxt;
  logic          done_q, done_nxt;

  logic          mem_wr_c;
  logic [AW-1:0] mem_addr_c;
  logic          mem_d_c;
  logic          host_gnt_c;

  // State, clear pointer, read-return tag and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      tag_q     <= TAG_NONE;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      clr_cnt_q <= clr_cnt_nxt;
      tag_q     <= tag_nxt;
      done_q    <= done_nxt;
    end
  end

  // Port ownership, memory drive and next-state
  always_comb begin
    state_nxt   = state_q;
    clr_cnt_nxt = clr_cnt_q;
    tag_nxt     = TAG_NONE;
    done_nxt    = 1'b0;
    mem_wr_c    = 1'b0;
    mem_addr_c  = '0;
    mem_d_c     = 1'b0;
    host_gnt_c  = 1'b0;

    if (bus.scan_req) begin
      mem_addr_c = bus.scan_addr;
      tag_nxt    = TAG_SCAN;
    end else if (state_q == CLEAR) begin
      mem_wr_c   = 1'b1;
      mem_addr_c = clr_cnt_q;
      mem_d_c    = CLR_VAL;
      if (clr_cnt_q == LAST_ADDR) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else begin
        clr_cnt_nxt = clr_cnt_q + AW'(1);
      end
    end else if (bus.host_req) begin
      host_gnt_c = 1'b1;
      mem_wr_c   = bus.host_wr;
      mem_addr_c = bus.host_addr;
      mem_d_c    = bus.host_din;
      tag_nxt    = bus.host_wr ? TAG_NONE : TAG_HOST;
    end

    // A start while already clearing is ignored
    if ((state_q == IDLE) && bus.clr_start) begin
      state_nxt   = CLEAR;
      clr_cnt_nxt = '0;
    end

    // Keep the memory write-protected and the host ungranted during reset
    if (!rst_n) begin
      mem_wr_c   = 1'b0;
      host_gnt_c = 1'b0;
    end
  end

  assign bus.mem_wr    = mem_wr_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_d     = mem_d_c;
  assign bus.host_gnt  = host_gnt_c;

  assign bus.scan_vld  = (tag_q == TAG_SCAN);
  assign bus.scan_pix  = (tag_q == TAG_SCAN) & bus.mem_q;
  assign bus.host_rvld = (tag_q == TAG_HOST);
  assign bus.host_dout = (tag_q == TAG_HOST) & bus.mem_q;
  assign bus.clr_busy  = (state_q == CLEAR);
  assign bus.clr_done  = done_q;
endmodule

// File: tb/tb_mem_disp_ctrl.sv
// Self-checking bench for mem_disp_ctrl with a behavioural 1x1024 display memory
// and a scoreboard of expected read returns.
module tb_mem_disp_ctrl;
  logic clk = 1'b0;
  logic rst_n;

  mem_disp_ctrl_if bus ();

  mem_disp_ctrl #(.CLR_VAL(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Display memory: synchronous write, registered read
  bit mem_arr [1024];
  always @(posedge clk) begin
    if (bus.mem_wr === 1'b1) mem_arr[bus.mem_addr] <= bus.mem_d;
    bus.mem_q <= mem_arr[bus.mem_addr];
  end

  typedef struct {
    bit host;
    bit data;
    int addr;
  } exp_t;

  exp_t exp_q [$];
  bit   ref_mem [1024];
  int   total = 0;
  int   bad   = 0;

  // Negedge sample: retire pending read returns, then log this cycle's accesses
  task automatic sample();
    exp_t e;
    bit   got;
    int   pending;
    @(negedge clk);
    pending = exp_q.size();
    if (bus.scan_vld === 1'b1 || bus.host_rvld === 1'b1) begin
      total++;
      if (pending == 0) begin
        bad++;
        $display("FAIL unexpected_valid scan_vld=%b host_rvld=%b required no valid", bus.scan_vld, bus.host_rvld);
      end else begin
        e = exp_q.pop_front();
        if (bus.scan_vld !== !e.host || bus.host_rvld !== e.host) begin
          bad++;
          $display("FAIL return_kind addr=%0d scan_vld=%b host_rvld=%b required host=%0d", e.addr, bus.scan_vld, bus.host_rvld, e.host);
        end else begin
          got = e.host ? bus.host_dout : bus.scan_pix;
          if (got !== e.data) begin
            bad++;
            $display("FAIL read_data addr=%0d host=%0d got=%b required=%b", e.addr, e.host, got, e.data);
          end
        end
      end
    end else if (pending != 0) begin
      total++;
      bad++;
      e = exp_q.pop_front();
      $display("FAIL missing_valid addr=%0d scan_vld=%b host_rvld=%b required valid", e.addr, bus.scan_vld, bus.host_rvld);
    end
    if (rst_n === 1'b1) begin
      if (bus.scan_req) begin
        exp_q.push_back('{host: 1'b0, data: ref_mem[bus.scan_addr], addr: int'(bus.scan_addr)});
      end else if (bus.host_req && bus.host_gnt === 1'b1) begin
        if (bus.host_wr) ref_mem[bus.host_addr] = bus.host_din;
        else exp_q.push_back('{host: 1'b1, data: ref_mem[bus.host_addr], addr: int'(bus.host_addr)});
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input bit v);
    for (int a = 0; a < 1024; a++) begin
      bus.host_req = 1'b1; bus.host_wr = 1'b1; bus.host_addr = 10'(a); bus.host_din = v;
      sample();
      total++;
      if (bus.host_gnt !== 1'b1) begin
        bad++;
        $display("FAIL fill_gnt addr=%0d got=%b required=1", a, bus.host_gnt);
      end
      next();
    end
    bus.host_req = 1'b0; bus.host_wr = 1'b0; bus.host_din = 1'b0;
  endtask

  task automatic readback();
    for (int a = 0; a < 1024; a++) begin
      bus.scan_req = 1'b1; bus.scan_addr = 10'(a);
      sample();
      next();
    end
    bus.scan_req = 1'b0;
    sample();
    next();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.scan_req = 1'b1; bus.scan_addr = 10'd7;
    bus.host_req = 1'b1; bus.host_wr = 1'b1; bus.host_addr = 10'd3; bus.host_din = 1'b1;
    bus.clr_start = 1'b0;
    #3;
    total++;
    if (bus.mem_wr !== 1'b0 || bus.host_gnt !== 1'b0) begin
      bad++;
      $display("FAIL reset_mem_wr mem_wr=%b host_gnt=%b required 0/0", bus.mem_wr, bus.host_gnt);
    end
    repeat (2) @(posedge clk);
    #1;
    bus.scan_req = 1'b0; bus.host_req = 1'b0; bus.host_wr = 1'b0; bus.host_din = 1'b0;
    total++;
    if ({bus.scan_vld, bus.scan_pix, bus.host_rvld, bus.host_dout, bus.clr_busy, bus.clr_done} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b required=000000",
               {bus.scan_vld, bus.scan_pix, bus.host_rvld, bus.host_dout, bus.clr_busy, bus.clr_done});
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sample();
      total++;
      if ({bus.scan_vld, bus.scan_pix, bus.host_rvld, bus.host_dout, bus.clr_busy, bus.clr_done,
           bus.mem_wr, bus.host_gnt} !== 8'b0) begin
        bad++;
        $display("FAIL idle_outputs cycle=%0d got=%b required=00000000", i,
                 {bus.scan_vld, bus.scan_pix, bus.host_rvld, bus.host_dout, bus.clr_busy, bus.clr_done,
                  bus.mem_wr, bus.host_gnt});
      end
      next();
    end
  endtask

  task automatic test_host();
    bus.host_req = 1'b1; bus.host_wr = 1'b1; bus.host_addr = 10'h155; bus.host_din = 1'b1;
    sample();
    total++;
    if ({bus.host_gnt, bus.mem_wr, bus.mem_d} !== 3'b111 || bus.mem_addr !== 10'h155) begin
      bad++;
      $display("FAIL host_write gnt/wr/d=%b addr=%h required 111 addr=155",
               {bus.host_gnt, bus.mem_wr, bus.mem_d}, bus.mem_addr);
    end
    next();
    bus.host_wr = 1'b0; bus.host_din = 1'b0;
    sample();
    total++;
    if (bus.host_gnt !== 1'b1 || bus.mem_wr !== 1'b0 || bus.mem_addr !== 10'h155) begin
      bad++;
      $display("FAIL host_read_gnt gnt=%b wr=%b addr=%h required 1 0 155", bus.host_gnt, bus.mem_wr, bus.mem_addr);
    end
    next();
    bus.host_req = 1'b0;
    sample();
    total++;
    if (bus.host_rvld !== 1'b1 || bus.host_dout !== 1'b1 || bus.host_gnt !== 1'b0) begin
      bad++;
      $display("FAIL host_read_ret rvld=%b dout=%b gnt=%b required 1 1 0", bus.host_rvld, bus.host_dout, bus.host_gnt);
    end
    next();
  endtask

  task automatic test_scan_priority();
    bus.host_req = 1'b1; bus.host_wr = 1'b1; bus.host_addr = 10'h2AA; bus.host_din = 1'b1;
    for (int a = 0; a < 1024; a++) begin
      bus.scan_req = 1'b1; bus.scan_addr = 10'(a);
      sample();
      total++;
      if (bus.host_gnt !== 1'b0 || bus.mem_wr !== 1'b0 || (a > 0 && bus.scan_vld !== 1'b1)) begin
        bad++;
        $display("FAIL scan_prio a=%0d gnt=%b wr=%b vld=%b required 0 0 1", a, bus.host_gnt, bus.mem_wr, bus.scan_vld);
      end
      next();
    end
    bus.scan_req = 1'b0;
    sample();
    total++;
    if (bus.host_gnt !== 1'b1 || bus.mem_addr !== 10'h2AA || bus.scan_vld !== 1'b1) begin
      bad++;
      $display("FAIL scan_release gnt=%b addr=%h vld=%b required 1 2aa 1", bus.host_gnt, bus.mem_addr, bus.scan_vld);
    end
    next();
    bus.host_req = 1'b0;
    sample();
    next();
  endtask

  task automatic test_clear_full();
    int busy_cnt = 0;
    int done_k   = -1;
    int done_cnt = 0;
    fill(1'b1);
    bus.clr_start = 1'b1;
    bus.host_req = 1'b1; bus.host_wr = 1'b1; bus.host_addr = 10'd5; bus.host_din = 1'b1;
    sample();
    total++;
    if (bus.host_gnt !== 1'b1 || bus.clr_busy !== 1'b0) begin
      bad++;
      $display("FAIL clr_with_host gnt=%b busy=%b required 1 0", bus.host_gnt, bus.clr_busy);
    end
    next();
    bus.clr_start = 1'b0; bus.host_req = 1'b0;
    for (int k = 1; k <= 1100; k++) begin
      sample();
      if (bus.clr_busy === 1'b1) busy_cnt++;
      if (bus.clr_done === 1'b1) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      next();
      if (done_k > 0 && k >= done_k + 2) break;
    end
    total++;
    if (busy_cnt != 1024 || done_k != 1025 || done_cnt != 1) begin
      bad++;
      $display("FAIL clr_full busy=%0d done_at=%0d done_pulses=%0d required 1024 1025 1", busy_cnt, done_k, done_cnt);
    end
    foreach (ref_mem[i]) ref_mem[i] = 1'b0;
    readback();
  endtask

  task automatic test_clear_scan();
    int busy_cnt = 0;
    int done_k   = -1;
    int done_cnt = 0;
    int scans    = 0;
    fill(1'b1);
    bus.clr_start = 1'b1;
    sample();
    next();
    bus.clr_start = 1'b0;
    for (int k = 1; k <= 1400; k++) begin
      bus.scan_req  = (k % 4 == 0) && (k <= 1000);
      bus.clr_start = (k == 500);
      if (bus.scan_req) begin
        // Addresses below k/2 have already been overwritten by the clear
        bus.scan_addr = 10'($urandom % (k / 2));
        ref_mem[bus.scan_addr] = 1'b0;
        scans++;
      end
      sample();
      if (bus.clr_busy === 1'b1) busy_cnt++;
      if (bus.clr_done === 1'b1) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      next();
      if (done_k > 0 && k >= done_k + 2) break;
    end
    bus.scan_req = 1'b0; bus.clr_start = 1'b0;
    total++;
    if (busy_cnt != 1024 + scans || done_k != 1025 + scans || done_cnt != 1) begin
      bad++;
      $display("FAIL clr_scan busy=%0d done_at=%0d done_pulses=%0d required %0d %0d 1",
               busy_cnt, done_k, done_cnt, 1024 + scans, 1025 + scans);
    end
    foreach (ref_mem[i]) ref_mem[i] = 1'b0;
    readback();
  endtask

  task automatic test_reset_mid_clear();
    int done_cnt = 0;
    fill(1'b1);
    bus.clr_start = 1'b1;
    sample();
    next();
    bus.clr_start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      sample();
      next();
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0 || bus.mem_wr !== 1'b0) begin
      bad++;
      $display("FAIL clr_abort busy=%b done=%b wr=%b required 0 0 0", bus.clr_busy, bus.clr_done, bus.mem_wr);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sample();
      if (bus.clr_done !== 1'b0 || bus.clr_busy !== 1'b0) done_cnt++;
      next();
    end
    total++;
    if (done_cnt != 0) begin
      bad++;
      $display("FAIL clr_abort_after bad_cycles=%0d required 0", done_cnt);
    end
    for (int a = 0; a < 300; a++) ref_mem[a] = 1'b0;
    readback();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog sim_time=%0t required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_host();
    test_scan_priority();
    test_clear_full();
    test_clear_scan();
    test_reset_mid_clear();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
